fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32 core, and the consumer of the execute stage's branch outcome.
- Owns the PC and issues single-outstanding requests to instruction memory over a valid/ready request channel plus a response channel.
- Presents fetched instructions to decode through the IF/ID output register.
- Applies branch redirects and flushes coming back from EX.

---
 rtl/all_pkgs.sv | 20 ++
 rtl/if_skid_buf.sv | 44 ++++
 rtl/fetch_stage.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/all_pkgs.sv
// Shared core package: datapath width plus the fetch-stage types and constants.
package all_pkgs;

  localparam int WIDTH = 32;

  // Canonical RV32 NOP (addi x0, x0, 0), shown on IF/ID whenever it is empty.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Byte distance between sequential instruction words.
  localparam int PC_STEP = 4;

  // REQ: request driven; WAIT: one outstanding; HOLD: skid full; DRAIN: stale response owed.
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry pc+instr holding register. Parks a fetched instruction while
// decode is stalled and the IF/ID register is still occupied.
module if_skid_buf
  import all_pkgs::*;
#(
  parameter int WIDTH = all_pkgs::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [31:0]      i_instr,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_pc,
  output logic [31:0]      o_instr
);

  logic             r_valid;
  logic [WIDTH-1:0] r_pc;
  logic [31:0]      r_instr;

  // Entry register; clear wins over load so a flush can never be undone.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      // NOTE: the payload is reset too (it is one entry, not a memory), so its value is never X.
      r_pc    <= '0;
      r_instr <= INSTR_NOP;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests, fills the IF/ID register and applies EX branch redirects.
// Optional macro FETCH_PERF_CNT_EN adds saturating redirect/stall counters.
module fetch_stage
  import all_pkgs::*;
#(
  parameter int               WIDTH    = all_pkgs::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_branch,
  input  logic             ex_branch_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             id_stall,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_redirects,
  output logic [31:0]      perf_stall_cycles
`endif
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] r_fetch_pc;
  logic             r_if_valid;
  logic [WIDTH-1:0] r_if_pc;
  logic [31:0]      r_if_instr;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_seq_pc;
  logic             w_accept;
  logic             w_slot_free;
  logic             w_capture;
  logic             w_load_rsp;
  logic             w_load_skid;
  logic             w_skid_load;
  logic             w_skid_clear;
  logic             w_skid_valid;
  logic [WIDTH-1:0] w_skid_pc;
  logic [31:0]      w_skid_instr;

  // A taken flag alone is meaningless unless EX really holds a branch.
  assign w_redirect  = ex_branch & ex_branch_taken;
  assign w_target    = ex_target & ~WIDTH'(3);
  assign w_seq_pc    = r_fetch_pc + WIDTH'(PC_STEP);
  assign w_slot_free = ~r_if_valid | ~id_stall;

  // Request is held low during the reset cycle itself.
  assign imem_req_valid = (r_state == REQ) & ~rst;
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  // Next-state, next-PC and datapath strobes; a redirect overrides everything.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    w_load_rsp   = 1'b0;
    w_load_skid  = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    case (r_state)
      REQ: begin
        if (w_accept) begin
          w_capture    = 1'b1;
          // An address accepted alongside a redirect is still owed a response.
          w_state_next = w_redirect ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (w_redirect) begin
          w_state_next = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          w_pc_next = w_seq_pc;
          if (w_slot_free) begin
            w_load_rsp   = 1'b1;
            w_state_next = REQ;
          end else begin
            w_skid_load  = 1'b1;
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_redirect) begin
          w_state_next = REQ;
        end else if (!id_stall && w_skid_valid) begin
          w_load_skid  = 1'b1;
          w_skid_clear = 1'b1;
          w_state_next = REQ;
        end
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          w_state_next = REQ;
        end
      end
      default: w_state_next = REQ;
    endcase
    if (w_redirect) begin
      w_pc_next    = w_target;
      w_skid_clear = 1'b1;
      w_load_rsp   = 1'b0;
      w_load_skid  = 1'b0;
      w_skid_load  = 1'b0;
    end
  end

  // State, PC and in-flight fetch address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_capture) begin
        r_fetch_pc <= r_pc;
      end
    end
  end

  // IF/ID register: flush, then new response, then skid refill, then consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= INSTR_NOP;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
      r_if_instr <= INSTR_NOP;
    end else if (w_load_rsp) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= r_fetch_pc;
      r_if_instr <= imem_rsp_data;
    end else if (w_load_skid) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= w_skid_pc;
      r_if_instr <= w_skid_instr;
    end else if (!id_stall) begin
      // Decode took the instruction this cycle and nothing replaces it.
      r_if_valid <= 1'b0;
      r_if_instr <= INSTR_NOP;
    end
  end

  assign if_valid = r_if_valid;
  assign if_pc    = r_if_pc;
  assign if_instr = r_if_instr;

  if_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (r_fetch_pc),
    .i_instr (imem_rsp_data),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_redirects;
  logic [31:0] r_perf_stall_cycles;

  // Saturating event counters for redirects and stalled-occupied cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_redirects    <= '0;
      r_perf_stall_cycles <= '0;
    end else begin
      if (w_redirect && (r_perf_redirects != 32'hFFFF_FFFF)) begin
        r_perf_redirects <= r_perf_redirects + 32'd1;
      end
      if (id_stall && r_if_valid && (r_perf_stall_cycles != 32'hFFFF_FFFF)) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
    end
  end

  assign perf_redirects    = r_perf_redirects;
  assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a hand-derived cycle table for the directed corner
// cases, then a randomised memory/stall run checked through a scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_branch;
  logic        ex_branch_taken;
  logic [31:0] ex_target;
  logic        id_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stall_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_branch       (ex_branch),
    .ex_branch_taken (ex_branch_taken),
    .ex_target       (ex_target),
    .id_stall        (id_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of directed stimulus plus the outputs expected in that cycle.
  typedef struct {
    logic        rst;
    logic        ready;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        stall;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_ins;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv_i,
                              input logic [31:0] d, input logic br, input logic tk,
                              input logic [31:0] tgt, input logic st, input logic erv,
                              input logic [31:0] era, input logic eiv,
                              input logic [31:0] eipc, input logic [31:0] eins);
    vec_t v;
    v.rst = r;   v.ready = rdy; v.rsp_v = rv_i; v.rsp_d = d;
    v.br  = br;  v.tk = tk;     v.tgt = tgt;    v.stall = st;
    v.e_rv = erv; v.e_ra = era; v.e_iv = eiv;   v.e_ipc = eipc; v.e_ins = eins;
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic drive(input logic r, input logic rdy, input logic rv_i, input logic [31:0] d,
                       input logic br, input logic tk, input logic [31:0] tgt, input logic st);
    rst             = r;
    imem_req_ready  = rdy;
    imem_rsp_valid  = rv_i;
    imem_rsp_data   = d;
    ex_branch       = br;
    ex_branch_taken = tk;
    ex_target       = tgt;
    id_stall        = st;
  endtask

  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] pend_addr;
    logic [31:0] next_addr;
    logic        hold_chk;
    logic [31:0] hold_addr;
    int          consumed;
    logic        rdy, st, rspv;
    logic [31:0] rspd;
    exp_t        e;

    // ---- directed cycle table (cycle index = cycles after reset release) ----
    //                   rst rdy rv  rsp_d          br tk tgt            st   rv ra            iv ipc            ins
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         NOP));          // 0
    vecs.push_back(mk(0, 0, 1, TAG|32'h0,      0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 1
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h4,         1, 32'h0,         TAG|32'h0));    // 2
    vecs.push_back(mk(0, 0, 1, TAG|32'h4,      0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 3
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         1,  1, 32'h8,         1, 32'h4,         TAG|32'h4));    // 4
    vecs.push_back(mk(0, 0, 1, TAG|32'h8,      0, 0, 32'h0,         1,  0, 32'h0,         1, 32'h4,         TAG|32'h4));    // 5
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1,  0, 32'h0,         1, 32'h4,         TAG|32'h4));    // 6
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,  0, 32'h0,         1, 32'h4,         TAG|32'h4));    // 7
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'hC,         1, 32'h8,         TAG|32'h8));    // 8
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'hC,         0, 32'h0,         NOP));          // 9
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 1, 32'h100,       0,  0, 32'h0,         0, 32'h0,         NOP));          // 10
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 11
    vecs.push_back(mk(0, 0, 1, TAG|32'hC,      0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 12
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h100,       0, 32'h0,         NOP));          // 13
    vecs.push_back(mk(0, 0, 1, TAG|32'h100,    1, 1, 32'h102,       0,  0, 32'h0,         0, 32'h0,         NOP));          // 14
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h100,       0, 32'h0,         NOP));          // 15
    vecs.push_back(mk(0, 0, 1, TAG|32'h100,    0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 16
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 1, 32'h200,       0,  1, 32'h104,       1, 32'h100,       TAG|32'h100));  // 17
    vecs.push_back(mk(0, 0, 1, TAG|32'h104,    0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 18
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 1, 32'h300,       1,  1, 32'h108,       1, 32'h104,       TAG|32'h104));  // 19
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1,  1, 32'h300,       0, 32'h0,         NOP));          // 20
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h300,       0, 32'h0,         NOP));          // 21
    vecs.push_back(mk(0, 0, 1, TAG|32'h300,    0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 22
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 1, 32'h400,       0,  1, 32'h304,       1, 32'h300,       TAG|32'h300));  // 23
    vecs.push_back(mk(0, 0, 1, TAG|32'h304,    0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 24
    vecs.push_back(mk(0, 0, 0, 32'h0,          1, 1, 32'hFFFF_FFFE, 0,  1, 32'h400,       0, 32'h0,         NOP));          // 25
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'hFFFF_FFFC, 0, 32'h0,         NOP));          // 26
    vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 27
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1,  1, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC)); // 28
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         1,  1, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC)); // 29
    vecs.push_back(mk(0, 0, 1, TAG|32'h0,      0, 0, 32'h0,         1,  0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC)); // 30
    vecs.push_back(mk(1, 0, 0, 32'h0,          0, 0, 32'h0,         1,  0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC)); // 31
    vecs.push_back(mk(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,  1, 32'h0,         0, 32'h0,         NOP));          // 32
    vecs.push_back(mk(0, 0, 1, TAG|32'h0,      0, 0, 32'h0,         0,  0, 32'h0,         0, 32'h0,         NOP));          // 33
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1,  1, 32'h4,         1, 32'h0,         TAG|32'h0));    // 34

    // ---- reset state ----
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_req_valid", 32'(imem_req_valid), 32'd0);
    check("reset_if_valid",  32'(if_valid),       32'd0);
    check("reset_if_pc",     if_pc,               32'h0);
    check("reset_if_instr",  if_instr,            NOP);

    // ---- directed table ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ready, vecs[i].rsp_v, vecs[i].rsp_d,
            vecs[i].br, vecs[i].tk, vecs[i].tgt, vecs[i].stall);
      #1;
      check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_ra);
      check($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) check($sformatf("v%0d_if_pc", i), if_pc, vecs[i].e_ipc);
      check($sformatf("v%0d_if_instr", i), if_instr, vecs[i].e_ins);
`ifdef FETCH_PERF_CNT_EN
      if (i == 31) begin
        check("perf_redirects_pre_rst",    perf_redirects,    32'd5);
        check("perf_stall_cycles_pre_rst", perf_stall_cycles, 32'd7);
      end
      if (i == 32) begin
        check("perf_redirects_post_rst",    perf_redirects,    32'd0);
        check("perf_stall_cycles_post_rst", perf_stall_cycles, 32'd0);
      end
`endif
    end

    // ---- randomised memory + stall run, checked through a scoreboard ----
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    pend      = 1'b0;
    cnt       = 0;
    pend_addr = '0;
    next_addr = 32'h0;
    hold_chk  = 1'b0;
    hold_addr = '0;
    consumed  = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) @(negedge clk);
      rdy  = ($urandom_range(0, 9) < 7);
      st   = ($urandom_range(0, 3) == 0);
      rspv = 1'b0;
      rspd = '0;
      if (pend) begin
        if (cnt == 0) begin
          rspv = 1'b1;
          rspd = pend_addr | TAG;
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      // Taken flag toggles randomly with ex_branch low: it must never redirect.
      drive(0, rdy, rspv, rspd, 0, 1'($urandom_range(0, 1)), $urandom, st);
      #1;
      if (hold_chk) begin
        check("sb_req_held_valid", 32'(imem_req_valid), 32'd1);
        check("sb_req_held_addr",  imem_req_addr,       hold_addr);
      end
      hold_chk  = imem_req_valid & ~rdy;
      hold_addr = imem_req_addr;
      if (imem_req_valid && rdy) begin
        check("sb_single_outstanding", 32'(pend), 32'd0);
        check("sb_req_addr", imem_req_addr, next_addr);
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        cnt       = $urandom_range(0, 2);
        exp_q.push_back('{pc: next_addr, instr: next_addr | TAG});
        next_addr = next_addr + 32'd4;
      end
      if (if_valid && !st) begin
        check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_if_pc",    if_pc,    e.pc);
          check("sb_if_instr", if_instr, e.instr);
          consumed++;
        end
      end
      if (!if_valid) check("sb_empty_nop", if_instr, NOP);
    end
    check("sb_progress", 32'(consumed >= 50), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
